// File: rtl/prio_arbiter_rr_pkg.sv
// Shared constants, FSM state type and the index-width helper for the
// priority / round-robin arbiter.
package prio_arbiter_rr_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational N-to-W priority encoder: reports the highest set index of
// in_vec, with vld flagging that any bit was set.
module prio_enc
   import prio_arbiter_rr_pkg::*;
#(
   parameter int N = 8,
   parameter int W = clog2(N)
) (
   input  logic [N-1:0] in_vec,
   output logic [W-1:0] idx,
   output logic         vld
);

   always_comb begin
      idx = '0;
      vld = |in_vec;
      // Ascending scan so the last (highest) set bit wins.
      for (int i = 0; i < N; i++) begin
         if (in_vec[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Sticky-grant arbiter with selectable fixed (highest index wins) or
// round-robin arbitration; grants are registered and held until ack.
module prio_arbiter_rr
   import prio_arbiter_rr_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         mode,
   input  logic         ack,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_idx,
   output logic [N-1:0] gnt_onehot
);

   state_e         state_q, state_d;
   logic [W-1:0]   gnt_idx_q, gnt_idx_d;
   logic [N-1:0]   gnt_onehot_q, gnt_onehot_d;
   logic [W-1:0]   rr_ptr_q, rr_ptr_d;

   logic           arb;
   logic [N-1:0]   cand;
   logic [W-1:0]   ptr_eff;
   logic [W-1:0]   start;
   logic [N-1:0]   rot;
   logic [N-1:0]   rev;
   logic [N-1:0]   enc_in;
   logic [W-1:0]   enc_idx;
   logic           enc_vld;
   logic [W:0]     rr_sum;
   logic [W-1:0]   win_idx;

   // Candidate vector and search origin for this edge's arbitration.
   // On an ack, the pointer that matters is the one being committed now.
   always_comb begin
      arb     = 1'b0;
      cand    = '0;
      ptr_eff = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            arb  = 1'b1;
            cand = req;
         end
         ST_GRANT: begin
            if (ack) begin
               arb     = 1'b1;
               cand    = req & ~gnt_onehot_q;
               ptr_eff = gnt_idx_q;
            end
         end
         default: ;
      endcase

      start = (ptr_eff == W'(N - 1)) ? '0 : ptr_eff + W'(1);
      rot   = N'({cand, cand} >> start);
      // The encoder picks the highest bit; reversing turns that into
      // "first set bit ascending from start".
      for (int i = 0; i < N; i++) rev[i] = rot[N-1-i];
      enc_in = (mode == MODE_RR) ? rev : cand;
   end

   prio_enc #(.N(N), .W(W)) u_enc (
      .in_vec (enc_in),
      .idx    (enc_idx),
      .vld    (enc_vld)
   );

   always_comb begin
      rr_sum = {1'b0, start} + {1'b0, W'(N - 1) - enc_idx};
      if (rr_sum >= (W + 1)'(N)) rr_sum = rr_sum - (W + 1)'(N);
      win_idx = (mode == MODE_RR) ? rr_sum[W-1:0] : enc_idx;

      state_d   = state_q;
      gnt_idx_d = gnt_idx_q;
      rr_ptr_d  = rr_ptr_q;
      if (state_q == ST_GRANT && ack) rr_ptr_d = gnt_idx_q;
      if (arb) begin
         if (enc_vld) begin
            state_d   = ST_GRANT;
            gnt_idx_d = win_idx;
         end else begin
            state_d = ST_IDLE;
         end
      end
      gnt_onehot_d = (state_d == ST_GRANT) ? (N'(1) << gnt_idx_d) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         gnt_idx_q    <= '0;
         gnt_onehot_q <= '0;
         rr_ptr_q     <= W'(N - 1);
      end else begin
         state_q      <= state_d;
         gnt_idx_q    <= gnt_idx_d;
         gnt_onehot_q <= gnt_onehot_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign gnt_valid  = (state_q == ST_GRANT);
   assign gnt_idx    = gnt_idx_q;
   assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Randomized and directed checks of prio_arbiter_rr (N=4) against a
// behavioural arbitration model.
module tb_prio_arbiter_rr;

   localparam int N = 4;
   localparam int W = 2;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic         mode;
   logic         ack;
   logic         gnt_valid;
   logic [W-1:0] gnt_idx;
   logic [N-1:0] gnt_onehot;

   int n_tests = 0;
   int n_fail  = 0;

   int m_v, m_idx, m_ptr;

   prio_arbiter_rr #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .mode       (mode),
      .ack        (ack),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Fixed: highest set index. Round-robin: first set index after p, mod N.
   function automatic int pick(input int c, input int m, input int p);
      if (m == 0) begin
         for (int i = N - 1; i >= 0; i--) if (c[i]) return i;
      end else begin
         for (int k = 1; k <= N; k++) if (c[(p + k) % N]) return (p + k) % N;
      end
      return 0;
   endfunction

   // One clock: drive at negedge, advance model, check #1 after posedge.
   task automatic step(input logic r, input logic [N-1:0] rq, input logic md, input logic a);
      int c;
      @(negedge clk);
      rst = r; req = rq; mode = md; ack = a;
      if (r) begin
         m_v = 0; m_idx = 0; m_ptr = N - 1;
      end else if (m_v == 0) begin
         if (rq != 0) begin
            m_v = 1; m_idx = pick(int'(rq), int'(md), m_ptr);
         end
      end else if (a) begin
         m_ptr = m_idx;
         c = int'(rq) & ~(1 << m_idx);
         if (c != 0) m_idx = pick(c, int'(md), m_ptr);
         else m_v = 0;
      end
      @(posedge clk);
      #1;
      chk("valid", int'(gnt_valid), m_v);
      chk("onehot", int'(gnt_onehot), m_v ? (1 << m_idx) : 0);
      if (m_v != 0) chk("idx", int'(gnt_idx), m_idx);
   endtask

   initial begin
      int exp_seq[4];
      rst = 1'b1; req = '0; mode = 1'b0; ack = 1'b0;
      m_v = 0; m_idx = 0; m_ptr = N - 1;

      step(1, 4'b0000, 0, 0);
      step(1, 4'b1111, 1, 1);
      chk("rst_valid", int'(gnt_valid), 0);
      chk("rst_idx", int'(gnt_idx), 0);
      chk("rst_onehot", int'(gnt_onehot), 0);

      // Fixed priority then sticky grant
      step(0, 4'b0110, 0, 0);
      chk("fixed_idx", int'(gnt_idx), 2);
      chk("fixed_onehot", int'(gnt_onehot), 4);
      step(0, 4'b0000, 0, 0);
      chk("sticky_idx", int'(gnt_idx), 2);
      step(0, 4'b0000, 1, 0);
      chk("mode_chg_idx", int'(gnt_idx), 2);
      step(0, 4'b0000, 0, 1);
      chk("ack_idle", int'(gnt_valid), 0);

      // Round-robin rotation, back-to-back
      step(1, 4'b0000, 0, 0);
      step(0, 4'b1111, 1, 0);
      chk("rr_first", int'(gnt_idx), 0);
      exp_seq = '{1, 2, 3, 0};
      for (int i = 0; i < 4; i++) begin
         step(0, 4'b1111, 1, 1);
         chk("rr_seq", int'(gnt_idx), exp_seq[i]);
         chk("rr_nobubble", int'(gnt_valid), 1);
      end

      // Wrap and mask
      step(1, 4'b0000, 0, 0);
      step(0, 4'b1000, 1, 0);
      chk("wrap_idx", int'(gnt_idx), 3);
      step(0, 4'b1001, 1, 1);
      chk("mask_idx", int'(gnt_idx), 0);

      // Fixed mode excludes the acked index for one arbitration only
      step(1, 4'b0000, 0, 0);
      step(0, 4'b1001, 0, 0);
      chk("fx_top", int'(gnt_idx), 3);
      step(0, 4'b1001, 0, 1);
      chk("fx_mask", int'(gnt_idx), 0);
      step(0, 4'b1001, 0, 1);
      chk("fx_again", int'(gnt_idx), 3);

      // Mid-operation reset
      step(1, 4'b0000, 0, 0);
      step(0, 4'b0010, 1, 0);
      chk("mid_idx", int'(gnt_idx), 1);
      step(1, 4'b1111, 1, 1);
      chk("mid_rst_v", int'(gnt_valid), 0);
      chk("mid_rst_oh", int'(gnt_onehot), 0);
      chk("mid_rst_idx", int'(gnt_idx), 0);
      step(0, 4'b1111, 1, 0);
      chk("post_rst_idx", int'(gnt_idx), 0);
      step(0, 4'b0000, 1, 1);

      // No requests, ack toggling
      for (int i = 0; i < 10; i++) begin
         step(0, 4'b0000, logic'(i % 3 == 0), logic'(i % 2));
         chk("noreq_v", int'(gnt_valid), 0);
      end

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         logic [N-1:0] rq;
         rq = ($urandom % 5 == 0) ? '0 : N'($urandom);
         step(logic'($urandom % 60 == 0), rq, logic'($urandom), logic'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
